// File: rtl/comp_nbit_pipe.sv
// Two-stage pipelined magnitude comparator with valid/ready handshake.
// Orders the operand pair so the larger one appears on o_data_big.
module comp_nbit_pipe #(
  parameter int unsigned SIZE_DATA = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  input  logic [1:0]           i_mode,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_less,
  output logic                 o_equal,
  output logic                 o_greater,
  output logic                 o_swap,
  output logic [SIZE_DATA-1:0] o_data_big,
  output logic [SIZE_DATA-1:0] o_data_small
);

  localparam int unsigned NNIB = SIZE_DATA / 4;

  typedef enum logic [1:0] {
    MODE_UNS  = 2'b00,
    MODE_TWOS = 2'b01,
    MODE_SMAG = 2'b10,
    MODE_MAG  = 2'b11
  } mode_e;

  logic                 s1_valid_q, s1_valid_d;
  logic [SIZE_DATA-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  mode_e                s1_mode_q, s1_mode_d;
  logic [NNIB-1:0]      s1_nlt_q, s1_nlt_d, s1_neq_q, s1_neq_d;

  logic                 s2_valid_q, s2_valid_d;
  logic                 less_q, less_d, equal_q, equal_d, greater_q, greater_d;
  logic [SIZE_DATA-1:0] big_q, big_d, small_q, small_d;

  logic                 s2_adv, s1_adv, accept;
  logic [SIZE_DATA-1:0] cmp_a, cmp_b;
  logic                 ult, ueq, sa, sb, a_mz, b_mz;

  assign s2_adv  = !s2_valid_q || i_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign o_ready = !s1_valid_q || !s2_valid_q || i_ready;
  assign accept  = i_valid && o_ready;

  // Stage 1: capture operands and per-nibble less/equal flags
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    s1_nlt_d   = s1_nlt_q;
    s1_neq_d   = s1_neq_q;
    cmp_a      = i_data_a;
    cmp_b      = i_data_b;
    if (i_mode[1]) begin
      cmp_a[SIZE_DATA-1] = 1'b0;
      cmp_b[SIZE_DATA-1] = 1'b0;
    end
    if (s1_adv) s1_valid_d = i_valid;
    if (accept) begin
      s1_a_d    = i_data_a;
      s1_b_d    = i_data_b;
      s1_mode_d = mode_e'(i_mode);
      for (int unsigned n = 0; n < NNIB; n++) begin
        s1_nlt_d[n] = cmp_a[4*n +: 4] <  cmp_b[4*n +: 4];
        s1_neq_d[n] = cmp_a[4*n +: 4] == cmp_b[4*n +: 4];
      end
    end
  end

  // Stage 2: ascending scan lets higher unequal nibbles override lower ones
  always_comb begin
    ult = 1'b0;
    ueq = 1'b1;
    for (int unsigned n = 0; n < NNIB; n++) begin
      if (!s1_neq_q[n]) ult = s1_nlt_q[n];
      ueq = ueq & s1_neq_q[n];
    end
  end

  assign sa   = s1_a_q[SIZE_DATA-1];
  assign sb   = s1_b_q[SIZE_DATA-1];
  assign a_mz = ~|s1_a_q[SIZE_DATA-2:0];
  assign b_mz = ~|s1_b_q[SIZE_DATA-2:0];

  always_comb begin
    s2_valid_d = s2_valid_q;
    less_d     = less_q;
    equal_d    = equal_q;
    greater_d  = greater_q;
    big_d      = big_q;
    small_d    = small_q;
    if (s2_adv) s2_valid_d = s1_valid_q;
    if (s2_adv && s1_valid_q) begin
      less_d  = ult;
      equal_d = ueq;
      unique case (s1_mode_q)
        MODE_UNS, MODE_MAG: begin
          less_d  = ult;
          equal_d = ueq;
        end
        MODE_TWOS: begin
          less_d  = (sa != sb) ? sa : ult;
          equal_d = ueq;
        end
        MODE_SMAG: begin
          if (a_mz && b_mz) begin
            less_d  = 1'b0;
            equal_d = 1'b1;
          end else if (sa != sb) begin
            less_d  = sa;
            equal_d = 1'b0;
          end else if (!sa) begin
            less_d  = ult;
            equal_d = ueq;
          end else begin
            less_d  = !ult && !ueq;
            equal_d = ueq;
          end
        end
        default: ;
      endcase
      greater_d = !less_d && !equal_d;
      big_d     = less_d ? s1_b_q : s1_a_q;
      small_d   = less_d ? s1_a_q : s1_b_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= MODE_UNS;
      s1_nlt_q   <= '0;
      s1_neq_q   <= '0;
      s2_valid_q <= 1'b0;
      less_q     <= 1'b0;
      equal_q    <= 1'b0;
      greater_q  <= 1'b0;
      big_q      <= '0;
      small_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_mode_q  <= s1_mode_d;
      s1_nlt_q   <= s1_nlt_d;
      s1_neq_q   <= s1_neq_d;
      s2_valid_q <= s2_valid_d;
      less_q     <= less_d;
      equal_q    <= equal_d;
      greater_q  <= greater_d;
      big_q      <= big_d;
      small_q    <= small_d;
    end
  end

  assign o_valid      = s2_valid_q;
  assign o_less       = less_q;
  assign o_equal      = equal_q;
  assign o_greater    = greater_q;
  assign o_swap       = less_q;
  assign o_data_big   = big_q;
  assign o_data_small = small_q;

endmodule

// File: tb/tb_comp_nbit_pipe.sv
// Bench for comp_nbit_pipe: 8-bit and 32-bit instances share one stimulus
// stream; a value-level model and an in-flight queue supply expectations.
module tb_comp_nbit_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0, rdy = 1'b0;
  logic [31:0] da = '0, db = '0;
  logic [1:0]  mode = '0;

  logic        ordy8, ov8, l8, e8, g8, s8;
  logic [7:0]  big8, sml8;
  logic        ordy32, ov32, l32, e32, g32, s32;
  logic [31:0] big32, sml32;

  always #5 clk = ~clk;

  comp_nbit_pipe #(.SIZE_DATA(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .o_ready(ordy8),
    .i_data_a(da[7:0]), .i_data_b(db[7:0]), .i_mode(mode),
    .o_valid(ov8), .i_ready(rdy), .o_less(l8), .o_equal(e8), .o_greater(g8),
    .o_swap(s8), .o_data_big(big8), .o_data_small(sml8));

  comp_nbit_pipe #(.SIZE_DATA(32)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .o_ready(ordy32),
    .i_data_a(da), .i_data_b(db), .i_mode(mode),
    .o_valid(ov32), .i_ready(rdy), .o_less(l32), .o_equal(e32), .o_greater(g32),
    .o_swap(s32), .o_data_big(big32), .o_data_small(sml32));

  typedef struct {
    logic [31:0] a, b;
    logic [1:0]  e8, e32;   // {less, equal}
    bit          c8, c32;   // which instance's result is checked
    int unsigned acc;
  } ent_t;

  typedef struct {
    logic [31:0] a, b;
    logic [1:0]  m;
    bit          w8;
    logic [1:0]  e;
  } vec_t;

  ent_t        q[$];
  int unsigned cyc = 0;
  int unsigned nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Value-level reference: map each operand to a signed integer, then compare.
  function automatic logic [1:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] m, input int unsigned w);
    longint unsigned msk, au, bu, top;
    longint va, vb, ma, mb;
    msk = (64'd1 << w) - 1;
    top = 64'd1 << (w - 1);
    au  = {32'd0, a} & msk;
    bu  = {32'd0, b} & msk;
    ma  = longint'(au & ~top);
    mb  = longint'(bu & ~top);
    case (m)
      2'b00: begin va = longint'(au); vb = longint'(bu); end
      2'b01: begin
        va = (au & top) != 0 ? longint'(au) - longint'(msk + 1) : longint'(au);
        vb = (bu & top) != 0 ? longint'(bu) - longint'(msk + 1) : longint'(bu);
      end
      2'b10: begin
        va = (au & top) != 0 ? -ma : ma;
        vb = (bu & top) != 0 ? -mb : mb;
      end
      default: begin va = ma; vb = mb; end
    endcase
    return {va < vb, va == vb};
  endfunction

  function automatic bit exp_valid();
    return q.size() > 0 && cyc > q[0].acc;
  endfunction

  task automatic check_outputs();
    bit          ev, l, e;
    ev = exp_valid();
    chk("valid8", {79'd0, ov8}, {79'd0, ev});
    chk("valid32", {79'd0, ov32}, {79'd0, ev});
    if (ev && q[0].c8) begin
      l = q[0].e8[1]; e = q[0].e8[0];
      chk("res8", {60'd0, l8, e8, g8, s8, big8, sml8},
          {60'd0, l, e, !l && !e, l, l ? q[0].b[7:0] : q[0].a[7:0], l ? q[0].a[7:0] : q[0].b[7:0]});
    end
    if (ev && q[0].c32) begin
      l = q[0].e32[1]; e = q[0].e32[0];
      chk("res32", {12'd0, l32, e32, g32, s32, big32, sml32},
          {12'd0, l, e, !l && !e, l, l ? q[0].b : q[0].a, l ? q[0].a : q[0].b});
    end
  endtask

  // One clock: check at negedge, drive, check o_ready, then track the edge.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] m, input bit r, input ent_t ent, output bit acc);
    bit er, pop;
    ent_t en;
    @(negedge clk);
    check_outputs();
    vld = v; da = a; db = b; mode = m; rdy = r;
    #1;
    er = (q.size() < 2) || r;
    chk("ready8", {79'd0, ordy8}, {79'd0, er});
    chk("ready32", {79'd0, ordy32}, {79'd0, er});
    acc = v && er;
    pop = exp_valid() && r;
    @(posedge clk);
    cyc++;
    if (pop) void'(q.pop_front());
    if (acc) begin
      en = ent; en.a = a; en.b = b; en.acc = cyc;
      q.push_back(en);
    end
  endtask

  function automatic ent_t model_ent(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    ent_t en;
    en.a = a; en.b = b; en.acc = 0;
    en.e8 = ref_cmp(a, b, m, 8); en.e32 = ref_cmp(a, b, m, 32);
    en.c8 = 1'b1; en.c32 = 1'b1;
    return en;
  endfunction

  task automatic idle(input int unsigned n);
    bit acc;
    ent_t dummy;
    dummy = model_ent('0, '0, '0);
    for (int unsigned i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b1, dummy, acc);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_8"}, {60'd0, ov8, l8, e8, g8, s8, ordy8, big8, sml8, 2'b00},
        {60'd0, 5'b00000, 1'b1, 8'd0, 8'd0, 2'b00});
    chk({nm, "_32"}, {14'd0, ov32, l32, e32, g32, s32, ordy32, big32, sml32},
        {14'd0, 5'b00000, 1'b1, 32'd0, 32'd0});
  endtask

  vec_t tbl[12];

  initial begin
    bit          acc, seen;
    int unsigned sent, stall;
    logic [31:0] ra, rb;
    logic [1:0]  rm;
    ent_t        en;

    tbl[0]  = '{32'h12, 32'h34, 2'b00, 1'b1, 2'b10};
    tbl[1]  = '{32'h5A, 32'h5A, 2'b00, 1'b1, 2'b01};
    tbl[2]  = '{32'h80, 32'h01, 2'b01, 1'b1, 2'b10};
    tbl[3]  = '{32'h80, 32'h01, 2'b00, 1'b1, 2'b00};
    tbl[4]  = '{32'h80000000, 32'h00000000, 2'b10, 1'b0, 2'b01};
    tbl[5]  = '{32'hC0000000, 32'hBF800000, 2'b10, 1'b0, 2'b10};
    tbl[6]  = '{32'hBF800000, 32'h40000000, 2'b11, 1'b0, 2'b10};
    tbl[7]  = '{32'h80, 32'h00, 2'b10, 1'b1, 2'b01};
    tbl[8]  = '{32'hFF, 32'h7F, 2'b11, 1'b1, 2'b01};
    tbl[9]  = '{32'h85, 32'h83, 2'b10, 1'b1, 2'b10};
    tbl[10] = '{32'h00, 32'h81, 2'b10, 1'b1, 2'b00};
    tbl[11] = '{32'h7FFFFFFF, 32'h80000000, 2'b01, 1'b0, 2'b00};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;

    // Directed vectors, one beat per cycle
    foreach (tbl[i]) begin
      en = model_ent(tbl[i].a, tbl[i].b, tbl[i].m);
      en.e8 = tbl[i].e; en.e32 = tbl[i].e;
      en.c8 = tbl[i].w8; en.c32 = !tbl[i].w8;
      step(1'b1, tbl[i].a, tbl[i].b, tbl[i].m, 1'b1, en, acc);
    end
    idle(4);

    // Backpressure: 4 back-to-back beats, i_ready low 3 cycles after first o_valid
    sent = 0; stall = 0; seen = 1'b0;
    for (int unsigned c = 0; c < 20 && (sent < 4 || q.size() > 0); c++) begin
      seen = seen || exp_valid();
      ra = 32'h1000_0000 * (sent + 1) + sent; rb = 32'h2345_6789 - sent;
      step(sent < 4, ra, rb, 2'(sent), !(seen && stall < 3),
           model_ent(ra, rb, 2'(sent)), acc);
      if (seen && stall < 3) stall++;
      if (acc) sent++;
    end
    chk("bp_beats_sent", {48'd0, sent}, {48'd0, 32'd4});
    idle(2);

    // Reset with two beats in flight
    step(1'b1, 32'h11, 32'h22, 2'b00, 1'b0, model_ent(32'h11, 32'h22, 2'b00), acc);
    step(1'b1, 32'h33, 32'h22, 2'b00, 1'b0, model_ent(32'h33, 32'h22, 2'b00), acc);
    @(negedge clk);
    vld = 1'b0; rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_state("midrst");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h07, 32'h03, 2'b00, 1'b1, model_ent(32'h07, 32'h03, 2'b00), acc);
    idle(3);

    // Randomized traffic against the reference model
    for (int unsigned c = 0; c < 600; c++) begin
      ra = $urandom; rb = $urandom; rm = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: rb = ra ^ 32'h8000_0080;
        2: begin ra = ra & 32'h8000_0080; rb = rb & 32'h8000_0080; end
        3: rb = (ra & 32'hFFFF_FF0F) | (rb & 32'h0000_00F0);
        default: ;
      endcase
      step($urandom_range(0, 9) < 7, ra, rb, rm, $urandom_range(0, 9) < 6,
           model_ent(ra, rb, rm), acc);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/comp_nbit_pipe.md
# comp_nbit_pipe

Parametrised, two-stage pipelined magnitude comparator with a valid/ready handshake and an operand-swap output. It generalises the 8-bit less-than comparator in four ways: any width that is a multiple of 4, less/equal/greater outputs, four compare modes including IEEE-style sign-magnitude, and backpressure. It sits at the front of the ADD_SUB datapath. It orders the two operands so that the alignment shifter always receives the larger magnitude on the "big" port.

## Interface
- SIZE_DATA, default 32: operand width. Must be a multiple of 4 and at least 8.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous and active-low.
- i_valid  input  1  upstream beat valid.
- o_ready  output  1  block can accept a beat this cycle.
- i_data_a  input  SIZE_DATA  operand A.
- i_data_b  input  SIZE_DATA  operand B.
- i_mode  input  2  compare mode, captured with the beat:
  - 00: unsigned.
  - 01: two's complement.
  - 10: sign-magnitude.
  - 11: magnitude only, MSB ignored.
- o_valid  output  1  result beat valid.
- i_ready  input  1  downstream accepts the result.
- o_less / o_equal / o_greater  output  1 each  A<B / A==B / A>B. Exactly one is set when o_valid=1.
- o_swap  output  1  equals o_less.
- o_data_big  output  SIZE_DATA  B if o_swap else A.
- o_data_small  output  SIZE_DATA  A if o_swap else B.

## Operation
- **Stage 1 (S1).** Registers A, B, mode, plus per-nibble less/equal vectors, SIZE_DATA/4 bits each, from 4-bit nibble compares.
  - Modes 10/11: nibble compares use operands with the MSB forced to 0.
  - Modes 00/01: nibble compares use the full operands.
- **Stage 2 (S2).** Reduces the nibble vectors MSB-first (the higher nibble decides unless its nibbles are equal) into ult/ueq. Applies the mode correction below, then registers the outputs.
- **Mode 00:** less=ult, equal=ueq.
- **Mode 01:** signs sa, sb.
  - sa≠sb: less=sa.
  - Otherwise less=ult.
  - equal=ueq.
- **Mode 10:**
  - Both magnitudes zero: equal (+0 == −0).
  - Else sa≠sb: less=sa.
  - Else sa=sb=0: less=ult.
  - Else sa=sb=1: less=!ult & !ueq.
  - equal=ueq & (sa==sb), except the zero case above.
- **Mode 11:** less=ult, equal=ueq on magnitudes. Ties give swap=0.
- greater = !less & !equal.
- Operands pass through unchanged; only their order changes.

## Timing
- Latency: 2 cycles from an accepted beat (i_valid & o_ready) to o_valid.
- Throughput: 1 beat per cycle when i_ready is held high.
- S2 advances when !s2_valid | i_ready.
- S1 advances when !s1_valid | S2 advances.
- o_ready = !s1_valid | !s2_valid | i_ready. This is combinational from i_ready.
- While o_valid & !i_ready, all outputs are held stable.
- With backpressure the pipeline holds at most 2 beats. Order is preserved; no beat is dropped or duplicated.
- i_valid, i_data_a, i_data_b and i_mode are ignored when o_ready=0.
- Reset at any time, including mid-stream:
  - Both stage valid bits clear asynchronously, so o_valid=0 immediately.
  - o_less, o_equal, o_greater, o_swap, o_data_big and o_data_small reset to 0.
  - o_ready is 1 after reset.
  - In-flight beats are discarded.
  - The first beat accepted after release emerges 2 cycles later.

## Test plan
- **Unsigned, SIZE_DATA=8.** Mode 00, A=0x12, B=0x34.
  - 2 cycles later: o_less=1, o_swap=1, big=0x34, small=0x12.
  - With A=B=0x5A: o_equal=1, o_swap=0.
- **Signed vs unsigned, SIZE_DATA=8.** A=0x80, B=0x01.
  - Mode 01 → o_less=1.
  - Mode 00 → o_greater=1, o_swap=0.
- **Sign-magnitude, SIZE_DATA=32.**
  - A=0x80000000, B=0x00000000 → o_equal=1.
  - A=0xC0000000, B=0xBF800000 → o_less=1, big=0xBF800000.
- **Magnitude only.** Mode 11, A=0xBF800000, B=0x40000000 → o_less=1, o_swap=1, big=0x40000000, small=0xBF800000.
- **Backpressure.** Send 4 back-to-back beats, hold i_ready=0 for 3 cycles after the first o_valid.
  - o_ready drops once 2 beats are held.
  - Outputs stay stable while stalled.
  - All 4 results arrive in order with correct values; no loss.
- **Reset mid-stream.** Assert i_rst_n=0 asynchronously with 2 beats in flight.
  - o_valid and all outputs go to 0 immediately; o_ready=1.
  - After release, a new beat A=0x07, B=0x03 (mode 00) gives o_greater=1 exactly 2 cycles after acceptance.
